// File: rtl/key_toggle_ctrl.sv
// key_toggle_ctrl
//   Debounces a raw push-button and toggles a run/stop level once per
//   accepted press.
//
//   Parameters
//     DEBOUNCE_TICKS : consecutive stable clk cycles needed to accept a key
//                      edge (legal range 2 .. 2^24-1)
//     INIT_RUN       : reset value of start_stop
//
//   Ports
//     clk        : single clock, rising edge
//     rst        : asynchronous, active-high reset
//     key_in     : raw asynchronous bouncing button, 1 = pressed
//     clear      : synchronous request forcing start_stop to 0
//     start_stop : registered run/stop level for the downstream counter
//     key_pulse  : registered one-cycle strobe per accepted press
//     key_state  : registered debounced key level
module key_toggle_ctrl #(
  parameter logic [23:0] DEBOUNCE_TICKS = 24'd2_000_000,
  parameter logic        INIT_RUN       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  input  logic clear,
  output logic start_stop,
  output logic key_pulse,
  output logic key_state
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    PRESSED,
    REL_CHK
  } state_t;

  localparam logic [23:0] CNT_MAX = DEBOUNCE_TICKS - 24'd1;

  logic        key_meta;
  logic        key_s;
  state_t      state;
  state_t      state_nxt;
  logic [23:0] cnt;
  logic [23:0] cnt_nxt;
  logic        accept;
  logic        key_state_nxt;

  // Two-flop synchronizer; only key_s is seen by the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_meta <= 1'b0;
      key_s    <= 1'b0;
    end else begin
      key_meta <= key_in;
      key_s    <= key_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      key_pulse  <= 1'b0;
      key_state  <= 1'b0;
      start_stop <= INIT_RUN;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      key_pulse <= accept;
      key_state <= key_state_nxt;
      // clear has priority over a toggle accepted in the same cycle.
      if (clear) begin
        start_stop <= 1'b0;
      end else if (accept) begin
        start_stop <= ~start_stop;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (key_s) begin
          state_nxt = PRESS_CHK;
          cnt_nxt   = '0;
        end
      end
      PRESS_CHK: begin
        if (!key_s) begin
          state_nxt = IDLE;
        end else if (cnt < CNT_MAX) begin
          cnt_nxt = cnt + 24'd1;
        end else begin
          state_nxt = PRESSED;
          accept    = 1'b1;
        end
      end
      PRESSED: begin
        if (!key_s) begin
          state_nxt = REL_CHK;
          cnt_nxt   = '0;
        end
      end
      REL_CHK: begin
        // A bounce back to pressed returns without a new pulse.
        if (key_s) begin
          state_nxt = PRESSED;
        end else if (cnt < CNT_MAX) begin
          cnt_nxt = cnt + 24'd1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    key_state_nxt = (state_nxt == PRESSED) || (state_nxt == REL_CHK);
  end

endmodule

// File: tb/tb_key_toggle_ctrl.sv
// tb_key_toggle_ctrl
//   Directed bench for key_toggle_ctrl with DEBOUNCE_TICKS=4, INIT_RUN=0.
//   Expected pulses (edge number and start_stop value) are queued by the
//   stimulus; a monitor pops one entry for every key_pulse it observes.
module tb_key_toggle_ctrl;

  logic clk;
  logic rst;
  logic key_in;
  logic clear;
  logic start_stop;
  logic key_pulse;
  logic key_state;

  typedef struct {
    int unsigned cyc;
    logic        ss;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc;
  int unsigned n_checks;
  int unsigned n_fail;

  key_toggle_ctrl #(
    .DEBOUNCE_TICKS(24'd4),
    .INIT_RUN      (1'b0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .clear     (clear),
    .start_stop(start_stop),
    .key_pulse (key_pulse),
    .key_state (key_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_num(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_edges(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge with key_in about to rise (or already held with rst
  // just released): the next posedge is sampling edge 0 and the pulse is
  // visible after edge 0+6.
  task automatic expect_pulse(input logic ss);
    exp_t e;
    e.cyc = cyc + 7;
    e.ss  = ss;
    exp_q.push_back(e);
  endtask

  // Monitor: every observed key_pulse must match the head of the queue.
  always @(negedge clk) begin
    if (key_pulse === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got key_pulse=1 at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_num("pulse_cycle", cyc, e.cyc);
        check_bit("pulse_start_stop", start_stop, e.ss);
        check_bit("pulse_key_state", key_state, 1'b1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    key_in   = 1'b0;
    clear    = 1'b0;

    // Reset values before any clock edge.
    #2;
    check_bit("reset_start_stop", start_stop, 1'b0);
    check_bit("reset_key_pulse", key_pulse, 1'b0);
    check_bit("reset_key_state", key_state, 1'b0);
    wait_edges(2);
    rst = 1'b0;
    wait_edges(2);

    // Glitch of 3 cycles: no pulse, no toggle.
    key_in = 1'b1;
    wait_edges(3);
    key_in = 1'b0;
    wait_edges(10);
    check_bit("glitch_key_state", key_state, 1'b0);
    check_bit("glitch_start_stop", start_stop, 1'b0);

    // Press 1 held 20 cycles: pulse after edge 6, start_stop 0->1.
    key_in = 1'b1;
    expect_pulse(1'b1);
    wait_edges(6);
    check_bit("pre_accept_key_state", key_state, 1'b0);
    check_bit("pre_accept_start_stop", start_stop, 1'b0);
    wait_edges(1);
    check_bit("accept_key_state", key_state, 1'b1);
    check_bit("accept_start_stop", start_stop, 1'b1);
    wait_edges(20);
    check_bit("held_key_state", key_state, 1'b1);
    key_in = 1'b0;
    wait_edges(10);
    check_bit("release1_key_state", key_state, 1'b0);

    // Press 2 with a 2-cycle release bounce: start_stop 1->0, one pulse only.
    key_in = 1'b1;
    expect_pulse(1'b0);
    wait_edges(12);
    key_in = 1'b0;
    wait_edges(2);
    key_in = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk);
      check_bit("bounce_key_state", key_state, 1'b1);
    end
    key_in = 1'b0;
    wait_edges(10);
    check_bit("release2_key_state", key_state, 1'b0);
    check_bit("release2_start_stop", start_stop, 1'b0);

    // Press 3 sets start_stop, then a lone clear drops it.
    key_in = 1'b1;
    expect_pulse(1'b1);
    wait_edges(10);
    key_in = 1'b0;
    wait_edges(10);
    check_bit("before_clear_start_stop", start_stop, 1'b1);
    clear = 1'b1;
    wait_edges(1);
    clear = 1'b0;
    check_bit("clear_start_stop", start_stop, 1'b0);

    // Press 4 with clear on the acceptance edge: clear wins, pulse still fires.
    key_in = 1'b1;
    expect_pulse(1'b0);
    wait_edges(6);
    clear = 1'b1;
    wait_edges(1);
    clear = 1'b0;
    check_bit("clear_accept_start_stop", start_stop, 1'b0);
    wait_edges(3);
    key_in = 1'b0;
    wait_edges(10);

    // Press 5, then async reset while pressed; key held -> re-qualified press.
    key_in = 1'b1;
    expect_pulse(1'b1);
    wait_edges(10);
    check_bit("pressed_key_state", key_state, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_bit("async_rst_start_stop", start_stop, 1'b0);
    check_bit("async_rst_key_state", key_state, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    expect_pulse(1'b1);
    wait_edges(10);
    key_in = 1'b0;
    wait_edges(10);

    // Press 6: reset mid-debounce (cnt=2), pending press discarded.
    key_in = 1'b1;
    wait_edges(5);
    check_bit("mid_chk_start_stop", start_stop, 1'b1);
    rst = 1'b1;
    #1;
    check_bit("mid_chk_rst_start_stop", start_stop, 1'b0);
    check_bit("mid_chk_rst_key_pulse", key_pulse, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    expect_pulse(1'b1);
    wait_edges(10);
    key_in = 1'b0;
    wait_edges(10);

    check_num("pending_pulses", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
